// File: rtl/traffic_fsm.sv
// traffic_fsm: intersection lamp sequencer sitting in front of the countdown
// timer. Each state loads one interval into the timer and waits for its
// expired pulse before choosing the next phase.
module traffic_fsm #(
  parameter int T_BASE = 6,
  parameter int T_EXT  = 3,
  parameter int T_YEL  = 2,
  parameter int T_WALK = 3
) (
  input  logic       clock,
  input  logic       reset_sync,
  input  logic       sensor,
  input  logic       walk_request,
  input  logic       expired,
  output logic       start_timer,
  output logic [3:0] value,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk_lamp
);

  localparam logic [2:0] S_MAIN_GREEN  = 3'd0;
  localparam logic [2:0] S_MAIN_YELLOW = 3'd1;
  localparam logic [2:0] S_WALK        = 3'd2;
  localparam logic [2:0] S_SIDE_GREEN  = 3'd3;
  localparam logic [2:0] S_SIDE_EXT    = 3'd4;
  localparam logic [2:0] S_SIDE_YELLOW = 3'd5;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  logic [2:0] state;
  logic [2:0] next_state;
  logic       walk_pending;
  logic       next_pending;
  logic       restart;
  logic       load;
  logic       fire;

  // Interval the timer is loaded with on entry to a state
  function automatic logic [3:0] interval_for(input logic [2:0] s);
    logic [3:0] v;
    v = 4'(T_BASE);
    case (s)
      S_MAIN_YELLOW, S_SIDE_YELLOW: v = 4'(T_YEL);
      S_WALK:                       v = 4'(T_WALK);
      S_SIDE_EXT:                   v = 4'(T_EXT);
      default:                      v = 4'(T_BASE);
    endcase
    return v;
  endfunction

  // Lamp pattern {main, side, walk} for a state; unknown codes show main green
  function automatic logic [6:0] lamps_for(input logic [2:0] s);
    logic [6:0] l;
    l = {LAMP_GREEN, LAMP_RED, 1'b0};
    case (s)
      S_MAIN_YELLOW: l = {LAMP_YELLOW, LAMP_RED, 1'b0};
      S_WALK:        l = {LAMP_RED, LAMP_RED, 1'b1};
      S_SIDE_GREEN:  l = {LAMP_RED, LAMP_GREEN, 1'b0};
      S_SIDE_EXT:    l = {LAMP_RED, LAMP_GREEN, 1'b0};
      S_SIDE_YELLOW: l = {LAMP_RED, LAMP_YELLOW, 1'b0};
      default:       l = {LAMP_GREEN, LAMP_RED, 1'b0};
    endcase
    return l;
  endfunction

  // An expiry only counts when the timer is not in its reload cycle
  assign fire = expired & ~start_timer;

  // Next-state choice; load marks every edge that restarts the timer
  always_comb begin
    next_state = state;
    load       = 1'b0;
    if (restart) begin
      next_state = S_MAIN_GREEN;
      load       = 1'b1;
    end else begin
      case (state)
        S_MAIN_GREEN: begin
          if (fire) begin
            load       = 1'b1;
            next_state = (sensor | walk_pending) ? S_MAIN_YELLOW : S_MAIN_GREEN;
          end
        end
        S_MAIN_YELLOW: begin
          if (fire) begin
            load       = 1'b1;
            next_state = walk_pending ? S_WALK : S_SIDE_GREEN;
          end
        end
        S_WALK: begin
          if (fire) begin
            load       = 1'b1;
            next_state = sensor ? S_SIDE_GREEN : S_MAIN_GREEN;
          end
        end
        S_SIDE_GREEN: begin
          if (fire) begin
            load       = 1'b1;
            next_state = sensor ? S_SIDE_EXT : S_SIDE_YELLOW;
          end
        end
        S_SIDE_EXT: begin
          if (fire) begin
            load       = 1'b1;
            next_state = S_SIDE_YELLOW;
          end
        end
        S_SIDE_YELLOW: begin
          if (fire) begin
            load       = 1'b1;
            next_state = S_MAIN_GREEN;
          end
        end
        default: begin
          load       = 1'b1;
          next_state = S_MAIN_GREEN;
        end
      endcase
    end
  end

  // Pedestrian request latch: entering WALK clears it, even against a new press
  always_comb begin
    next_pending = walk_pending;
    if (load && (next_state == S_WALK)) begin
      next_pending = 1'b0;
    end else if (walk_request && (state != S_WALK)) begin
      next_pending = 1'b1;
    end
  end

  // Registered state, lamps and timer load; reset shows main green at once
  always_ff @(posedge clock or posedge reset_sync) begin
    if (reset_sync) begin
      state        <= S_MAIN_GREEN;
      main_lights  <= LAMP_GREEN;
      side_lights  <= LAMP_RED;
      walk_lamp    <= 1'b0;
      start_timer  <= 1'b0;
      value        <= 4'(T_BASE);
      walk_pending <= 1'b0;
      restart      <= 1'b1;
    end else begin
      state        <= next_state;
      start_timer  <= load;
      restart      <= 1'b0;
      walk_pending <= next_pending;
      if (load) begin
        value                                <= interval_for(next_state);
        {main_lights, side_lights, walk_lamp} <= lamps_for(next_state);
      end
    end
  end

endmodule

// File: tb/tb_traffic_fsm.sv
// tb_traffic_fsm: randomized scoreboard bench for traffic_fsm. The bench plays
// the countdown timer and predicts every timer load from the phase rules.
module tb_traffic_fsm;

  localparam int T_BASE = 6;
  localparam int T_EXT  = 3;
  localparam int T_YEL  = 2;
  localparam int T_WALK = 3;

  logic       clock = 1'b0;
  logic       reset_sync;
  logic       sensor;
  logic       walk_request;
  logic       expired;
  logic       start_timer;
  logic [3:0] value;
  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic       walk_lamp;

  typedef enum int {PH_MAIN_GREEN, PH_MAIN_YELLOW, PH_WALK,
                    PH_SIDE_GREEN, PH_SIDE_EXT, PH_SIDE_YELLOW} phase_t;

  int        errors = 0;
  int        checks = 0;
  logic [10:0] exp_q[$];

  phase_t ph;
  bit     pend;
  bit     m_restart;
  bit     cur_start;
  bit     armed;
  int     cnt;

  traffic_fsm #(.T_BASE(T_BASE), .T_EXT(T_EXT), .T_YEL(T_YEL), .T_WALK(T_WALK)) dut (
    .clock(clock),
    .reset_sync(reset_sync),
    .sensor(sensor),
    .walk_request(walk_request),
    .expired(expired),
    .start_timer(start_timer),
    .value(value),
    .main_lights(main_lights),
    .side_lights(side_lights),
    .walk_lamp(walk_lamp)
  );

  always #5 clock = ~clock;

  function automatic int seconds(input phase_t p);
    case (p)
      PH_MAIN_YELLOW, PH_SIDE_YELLOW: return T_YEL;
      PH_WALK:                        return T_WALK;
      PH_SIDE_EXT:                    return T_EXT;
      default:                        return T_BASE;
    endcase
  endfunction

  // Expected {value, main, side, walk} seen during the first cycle of a phase
  function automatic logic [10:0] expect_for(input phase_t p);
    logic [6:0] l;
    case (p)
      PH_MAIN_GREEN:  l = {3'b001, 3'b100, 1'b0};
      PH_MAIN_YELLOW: l = {3'b010, 3'b100, 1'b0};
      PH_WALK:        l = {3'b100, 3'b100, 1'b1};
      PH_SIDE_GREEN:  l = {3'b100, 3'b001, 1'b0};
      PH_SIDE_EXT:    l = {3'b100, 3'b001, 1'b0};
      default:        l = {3'b100, 3'b010, 1'b0};
    endcase
    return {4'(seconds(p)), l};
  endfunction

  function automatic phase_t rule(input phase_t p, input bit s, input bit wp);
    case (p)
      PH_MAIN_GREEN:  return (s || wp) ? PH_MAIN_YELLOW : PH_MAIN_GREEN;
      PH_MAIN_YELLOW: return wp ? PH_WALK : PH_SIDE_GREEN;
      PH_WALK:        return s ? PH_SIDE_GREEN : PH_MAIN_GREEN;
      PH_SIDE_GREEN:  return s ? PH_SIDE_EXT : PH_SIDE_YELLOW;
      PH_SIDE_EXT:    return PH_SIDE_YELLOW;
      default:        return PH_MAIN_GREEN;
    endcase
  endfunction

  // One clock of stimulus: play the timer, predict the edge, then advance
  task automatic applyStimulus(input bit s, input bit w);
    bit     e;
    bit     fire;
    phase_t np;
    e = 1'b0;
    if (armed) begin
      if (cnt == 0) begin
        e     = 1'b1;
        armed = 1'b0;
      end else begin
        cnt--;
      end
    end
    if (cur_start && ($urandom_range(3) == 0)) e = 1'b1;
    sensor       = s;
    walk_request = w;
    expired      = e;
    fire = 1'b0;
    np   = ph;
    if (m_restart) begin
      fire      = 1'b1;
      np        = PH_MAIN_GREEN;
      m_restart = 1'b0;
    end else if (e && !cur_start) begin
      fire = 1'b1;
      np   = rule(ph, s, pend);
    end
    if (fire && np == PH_WALK) pend = 1'b0;
    else if (w && ph != PH_WALK) pend = 1'b1;
    if (fire) begin
      ph = np;
      exp_q.push_back(expect_for(np));
      armed = 1'b1;
      cnt   = seconds(np) + int'($urandom_range(1));
    end
    cur_start = fire;
    @(posedge clock);
    #1;
  endtask

  // Asynchronous reset pulse, lamps checked before any clock edge
  task automatic do_reset();
    sensor       = 1'b0;
    walk_request = 1'b0;
    expired      = 1'b0;
    reset_sync   = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("reset_state", {value, main_lights, side_lights, walk_lamp, start_timer},
                {4'(T_BASE), 3'b001, 3'b100, 1'b0, 1'b0});
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_sync = 1'b0;
    ph         = PH_MAIN_GREEN;
    pend       = 1'b0;
    m_restart  = 1'b1;
    cur_start  = 1'b0;
    armed      = 1'b0;
    cnt        = 0;
  endtask

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every timer load must match the oldest prediction
  always @(negedge clock) begin
    if (!reset_sync) begin
      checks++;
      if (!($onehot(main_lights) && $onehot(side_lights) && !(main_lights[0] && side_lights[0]))) begin
        errors++;
        $display("[TB] FAIL lamp_onehot: main=%b side=%b at %0t", main_lights, side_lights, $time);
      end
      if (start_timer) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_start: value=%0d main=%b side=%b walk=%b, no load expected at %0t",
                   value, main_lights, side_lights, walk_lamp, $time);
        end else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          checks++;
          if ({value, main_lights, side_lights, walk_lamp} !== e) begin
            errors++;
            $display("[TB] FAIL timer_load: got value=%0d lamps=%b/%b walk=%b, expected value=%0d lamps=%b/%b walk=%b at %0t",
                     value, main_lights, side_lights, walk_lamp, e[10:7], e[6:4], e[3:1], e[0], $time);
          end
        end
      end
    end
  end

  initial begin
    bit s;
    int guard;
    do_reset();

    // Rest in main green with no demand
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0);

    // Car held: full side cycle with one extension
    for (int i = 0; i < 60; i++) applyStimulus(1'b1, 1'b0);

    // Single walk press from main green, then walk press on the WALK-entry edge
    guard = 0;
    while (ph != PH_MAIN_GREEN && guard < 200) begin applyStimulus(1'b0, 1'b0); guard++; end
    applyStimulus(1'b0, 1'b1);
    guard = 0;
    while (!(ph == PH_MAIN_YELLOW && armed && cnt == 0) && guard < 200) begin
      applyStimulus(1'b0, 1'b0);
      guard++;
    end
    checkOutput("reach_yellow", {11'd0, ph == PH_MAIN_YELLOW}, 12'd1);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0);

    // Randomized traffic with sensor held for random spans
    s = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) s = ~s;
      applyStimulus(s, $urandom_range(19) == 0);
    end

    // Reset in the middle of a side extension with a walk pending
    guard = 0;
    while (ph != PH_SIDE_EXT && guard < 300) begin applyStimulus(1'b1, 1'b0); guard++; end
    checkOutput("reach_ext", {11'd0, ph == PH_SIDE_EXT}, 12'd1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0);

    @(negedge clock);
    #1;
    checkOutput("queue_drained", 12'(exp_q.size()), 12'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_fsm.md
Name: traffic_fsm

Overview:
- Intersection control state machine that sits directly upstream of the countdown timer.
- Drives the timer's start_timer/value load interface and consumes its one-cycle expired pulse.
- Produces main-street, side-street and pedestrian lamp outputs.
- Inputs are a side-street car sensor and a pedestrian walk button. Both are already synchronised to clock.

Parameters:
T_BASE, 6, green interval in seconds for MAIN_GREEN and SIDE_GREEN (legal 1..15)
T_EXT, 3, side-green extension in seconds when a car is still present (legal 1..15)
T_YEL, 2, yellow interval in seconds (legal 1..15)
T_WALK, 3, all-red pedestrian walk interval in seconds (legal 1..15)

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset_sync  input  1  asynchronous, active-high reset
sensor  input  1  side-street vehicle present (level)
walk_request  input  1  pedestrian button (pulse or level, any length)
expired  input  1  one-cycle pulse from timer: current interval elapsed
start_timer  output  1  one-cycle pulse: timer loads value
value  output  4  interval in seconds for the timer; registered, held stable for the whole state
main_lights  output  3  {red,yellow,green} for main street, one-hot
side_lights  output  3  {red,yellow,green} for side street, one-hot
walk_lamp  output  1  pedestrian walk indication

Behaviour:
- All outputs are registered. Reset is asynchronous active-high.
- Reset values: state=MAIN_GREEN, main_lights=001, side_lights=100, walk_lamp=0, start_timer=0, value=T_BASE, walk_pending=0, restart flag=1.
- First rising edge after reset deasserts: start_timer=1 for one cycle with value=T_BASE, and the restart flag clears.
- States and lamps:
  - MAIN_GREEN: main 001, side 100
  - MAIN_YELLOW: main 010, side 100
  - WALK: main 100, side 100, walk_lamp=1
  - SIDE_GREEN: main 100, side 001
  - SIDE_EXT: main 100, side 001
  - SIDE_YELLOW: main 100, side 010
- Transitions are taken only on a cycle with expired=1:
  - MAIN_GREEN: to MAIN_YELLOW if (sensor | walk_pending). Otherwise stay in MAIN_GREEN and reload T_BASE (rest in main green).
  - MAIN_YELLOW: to WALK if walk_pending, else to SIDE_GREEN.
  - WALK: to SIDE_GREEN if sensor, else to MAIN_GREEN.
  - SIDE_GREEN: to SIDE_EXT if sensor, else to SIDE_YELLOW.
  - SIDE_EXT: to SIDE_YELLOW. There is only one extension per side phase; sensor is ignored here.
  - SIDE_YELLOW: to MAIN_GREEN.
- Timer load timing:
  - On the edge that samples expired=1, the new state, lamps and value update together.
  - start_timer=1 is driven in that same registered update, so it is high during the first cycle of the new state.
  - A MAIN_GREEN self-reload also pulses start_timer.
  - value per state: MAIN_GREEN/SIDE_GREEN=T_BASE, SIDE_EXT=T_EXT, yellows=T_YEL, WALK=T_WALK.
- Latency: expired high in cycle N gives new lamps, value and start_timer=1 in cycle N+1. start_timer is 0 in cycle N+2.
- expired is ignored in any cycle where start_timer=1 (the timer is reloading).
- walk_pending:
  - Set by walk_request=1 in any state except WALK.
  - Cleared on the edge entering WALK. Clear wins over a simultaneous request.
  - Requests while in WALK are ignored.
- sensor is sampled only on the expiry cycle. There is no latching of sensor.
- Reset mid-interval: lamps return to main green immediately (asynchronously) and walk_pending clears. The restart pulse follows on the first edge after release.
- Lamp outputs are always one-hot per street. No state drives green on both streets.
- Illegal or unreachable state encodings go to MAIN_GREEN with start_timer=1 on the next edge.

Test Plan:
- Reset, sensor=0, walk=0. Pulse expired every 6 s-equivalent -> stays MAIN_GREEN (001/100). start_timer pulses after each expired with value=6; start_timer is seen one cycle after reset release.
- sensor=1 held through a full cycle -> sequence MAIN_GREEN(6) -> MAIN_YELLOW(2) -> SIDE_GREEN(6) -> SIDE_EXT(3) -> SIDE_YELLOW(2) -> MAIN_GREEN(6). Check value on each start_timer pulse matches these numbers.
- sensor=0, single-cycle walk_request during MAIN_GREEN -> MAIN_YELLOW(2) -> WALK(3, walk_lamp=1, both red) -> MAIN_GREEN. walk_pending is 0 after WALK entry.
- walk_request asserted on the same edge that enters WALK -> walk_pending=0 afterwards. No second WALK phase occurs.
- expired asserted during a start_timer=1 cycle -> no state change. Next genuine expired transitions normally.
- Assert reset_sync mid-SIDE_EXT with walk_pending=1 -> lamps go to 001/100 before the next edge and walk_pending=0. The first post-release edge gives start_timer=1, value=6.
